// File: rtl/decode_scoreboard.sv
// Decode-stage issue gate: one-entry holding register plus per-register
// pending-write scoreboard that blocks RAW hazards and counter overflow.
module decode_scoreboard #(
  parameter int NR_REGS    = 16,
  parameter int CNT_W      = 2,
  parameter int KILL_PORTS = 2,
  parameter int PAYLOAD_W  = 209
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic                    in_rs1_used,
  input  logic                    in_rs2_used,
  input  logic [4:0]              in_rd,
  input  logic                    in_rd_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [4:0]              out_rd,
  output logic                    out_rd_we,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_rd,
  input  logic [KILL_PORTS-1:0]   kill_valid,
  input  logic [5*KILL_PORTS-1:0] kill_rd,
  input  logic                    flush,
  output logic                    raw_stall,
  output logic [31:0]             stall_cycles,
  output logic                    err
);

  localparam int IW = $clog2(NR_REGS);
  localparam int SW = CNT_W + $clog2(KILL_PORTS + 2) + 1;
  localparam logic [4:0] MSK = 5'(NR_REGS - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic                 hold_valid;
  logic [PAYLOAD_W-1:0] h_payload;
  logic [IW-1:0]        h_rs1;
  logic [IW-1:0]        h_rs2;
  logic                 h_rs1_used;
  logic                 h_rs2_used;
  logic [4:0]           h_rd;
  logic                 h_rd_we;

  logic [CNT_W-1:0] cnt     [NR_REGS];
  logic [CNT_W-1:0] cnt_nxt [NR_REGS];
  logic [NR_REGS-1:0] uflow;

  logic [IW-1:0] rd_i;
  logic [IW-1:0] wb_i;
  logic          haz;
  logic          fire;
  logic          take;

  assign rd_i = IW'(h_rd & MSK);
  assign wb_i = IW'(wb_rd & MSK);

  always_comb begin
    haz = 1'b0;
    if (h_rs1_used && h_rs1 != '0 && cnt[h_rs1] != '0)
      haz = 1'b1;
    if (h_rs2_used && h_rs2 != '0 && cnt[h_rs2] != '0)
      haz = 1'b1;
    if (h_rd_we && rd_i != '0 && cnt[rd_i] == MAX)
      haz = 1'b1;
  end

  assign out_valid   = hold_valid & ~haz & ~flush;
  assign raw_stall   = hold_valid & haz & ~flush;
  assign fire        = out_valid & out_ready;
  assign in_ready    = ~hold_valid | fire;
  assign take        = in_valid & in_ready & ~flush;
  assign out_payload = h_payload;
  assign out_rd      = h_rd;
  assign out_rd_we   = h_rd_we;

  // Issue, writeback and every kill port net together per register.
  always_comb begin
    logic [SW-1:0] up;
    logic [SW-1:0] dn;
    up    = '0;
    dn    = '0;
    uflow = '0;
    for (int r = 0; r < NR_REGS; r++) begin
      cnt_nxt[r] = '0;
      up = SW'(cnt[r]);
      up = up + SW'(fire && h_rd_we && rd_i == IW'(r));
      dn = SW'(wb_valid && wb_i == IW'(r));
      for (int k = 0; k < KILL_PORTS; k++)
        dn = dn + SW'(kill_valid[k] &&
               IW'(kill_rd[5*k +: 5] & MSK) == IW'(r));
      if (r != 0) begin
        if (up < dn)
          uflow[r] = 1'b1;
        else
          cnt_nxt[r] = CNT_W'(up - dn);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid   <= 1'b0;
      stall_cycles <= '0;
      err          <= 1'b0;
      for (int r = 0; r < NR_REGS; r++)
        cnt[r] <= '0;
    end else begin
      if (flush)
        hold_valid <= 1'b0;
      else if (take)
        hold_valid <= 1'b1;
      else if (fire)
        hold_valid <= 1'b0;
      if (raw_stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (|uflow)
        err <= 1'b1;
      for (int r = 0; r < NR_REGS; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

  // Bundle fields are don't-care while empty, so they carry no reset.
  always_ff @(posedge clock) begin
    if (take) begin
      h_payload  <= in_payload;
      h_rs1      <= IW'(in_rs1 & MSK);
      h_rs2      <= IW'(in_rs2 & MSK);
      h_rs1_used <= in_rs1_used;
      h_rs2_used <= in_rs2_used;
      h_rd       <= in_rd;
      h_rd_we    <= in_rd_we;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios plus a randomized
// phase, all checked against a cycle-level behavioural model.
module tb_decode_scoreboard;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [208:0] in_payload;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic         in_rs1_used;
  logic         in_rs2_used;
  logic [4:0]   in_rd;
  logic         in_rd_we;
  logic         out_valid;
  logic         out_ready;
  logic [208:0] out_payload;
  logic [4:0]   out_rd;
  logic         out_rd_we;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [1:0]   kill_valid;
  logic [9:0]   kill_rd;
  logic         flush;
  logic         raw_stall;
  logic [31:0]  stall_cycles;
  logic         err;

  decode_scoreboard dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .flush(flush), .raw_stall(raw_stall),
    .stall_cycles(stall_cycles), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: pending writes per architectural register.
  int           mcnt [16];
  bit           mhv;
  logic [208:0] mpay;
  int           mrs1, mrs2, mrd;
  bit           mu1, mu2, mwe;
  logic [4:0]   mrd5;
  int unsigned  mstall;
  bit           merr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [208:0] rpay();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom};
    return t[208:0];
  endfunction

  function automatic bit mhaz();
    bit h;
    h = 0;
    if (mu1 && mrs1 != 0 && mcnt[mrs1] > 0) h = 1;
    if (mu2 && mrs2 != 0 && mcnt[mrs2] > 0) h = 1;
    if (mwe && mrd != 0 && mcnt[mrd] == 3) h = 1;
    return mhv && h;
  endfunction

  task automatic idle();
    in_valid = 0; in_payload = '0;
    in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rd = 0; in_rd_we = 0;
    wb_valid = 0; wb_rd = 0;
    kill_valid = 0; kill_rd = 0;
    flush = 0;
  endtask

  task automatic instr(input int rd, input bit we,
                       input int rs1, input bit u1,
                       input int rs2, input bit u2);
    in_valid = 1; in_payload = rpay();
    in_rd = 5'(rd); in_rd_we = we;
    in_rs1 = 5'(rs1); in_rs1_used = u1;
    in_rs2 = 5'(rs2); in_rs2_used = u2;
  endtask

  // One clock: compare against the model, then advance it.
  task automatic cyc();
    bit ov, rs, fire, ir;
    int d, n;
    #2;
    ov   = mhv && !mhaz() && !flush;
    rs   = mhaz() && !flush;
    fire = ov && out_ready;
    ir   = !mhv || fire;
    chk("out_valid", out_valid, ov);
    chk("raw_stall", raw_stall, rs);
    chk("in_ready", in_ready, ir);
    chk("stall_cycles", stall_cycles, mstall);
    chk("err", err, merr);
    if (ov) begin
      chk("out_rd", out_rd, mrd5);
      chk("out_rd_we", out_rd_we, mwe);
      chk("out_payload", out_payload === mpay, 1);
    end
    for (int r = 1; r < 16; r++) begin
      d = (wb_valid && wb_rd % 16 == r) ? 1 : 0;
      for (int k = 0; k < 2; k++)
        if (kill_valid[k] && kill_rd[5*k +: 5] % 16 == r) d++;
      n = mcnt[r] - d;
      if (fire && mwe && mrd == r) n++;
      if (n < 0) begin
        n = 0;
        merr = 1;
      end
      mcnt[r] = n;
    end
    if (rs) mstall++;
    if (flush) mhv = 0;
    else if (in_valid && ir) begin
      mhv = 1; mpay = in_payload;
      mrs1 = in_rs1 % 16; mrs2 = in_rs2 % 16; mrd = in_rd % 16;
      mu1 = in_rs1_used; mu2 = in_rs2_used; mwe = in_rd_we;
      mrd5 = in_rd;
    end else if (fire) mhv = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1;
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    foreach (mcnt[r]) mcnt[r] = 0;
    mhv = 0; mstall = 0; merr = 0;
    cyc();
  endtask

  initial begin
    int tmp [16];
    int r;
    reset = 1;
    idle();
    out_ready = 1;

    // Independent back-to-back issue
    do_reset();
    instr(5, 1, 0, 0, 0, 0); cyc();
    instr(6, 1, 7, 1, 0, 0);
    #1 chk("s1_issue_a", out_valid, 1);
    chk("s1_rd_a", out_rd, 5);
    cyc();
    idle();
    #1 chk("s1_issue_b", out_valid, 1);
    chk("s1_rd_b", out_rd, 6);
    cyc(); cyc();
    chk("s1_stalls", stall_cycles, 0);

    // RAW stall released by writeback
    do_reset();
    instr(5, 1, 0, 0, 0, 0); cyc();
    instr(9, 1, 5, 1, 0, 0); cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin wb_valid = 1; wb_rd = 5; end
      #1 chk("s2_stall", raw_stall, 1);
      cyc();
    end
    idle();
    #1 chk("s2_issue", out_valid, 1);
    chk("s2_stalls", stall_cycles, 3);
    cyc();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      instr(3, 1, 0, 0, 0, 0); cyc();
    end
    idle();
    #1 chk("s3_sat", raw_stall, 1);
    cyc();
    wb_valid = 1; wb_rd = 3;
    #1 chk("s3_sat_wb", raw_stall, 1);
    cyc();
    idle();
    #1 chk("s3_issue", out_valid, 1);
    cyc();
    instr(3, 1, 0, 0, 0, 0); cyc();
    idle();
    #1 chk("s3_full_again", raw_stall, 1);
    cyc();

    // Simultaneous issue, writeback and kill on one register
    do_reset();
    for (int i = 0; i < 3; i++) begin
      instr(8, 1, 0, 0, 0, 0); cyc();
    end
    idle();
    wb_valid = 1; wb_rd = 8;
    kill_valid = 2'b10; kill_rd = {5'd8, 5'd0};
    #1 chk("s4_issue", out_valid, 1);
    cyc();
    idle(); cyc();
    chk("s4_err", err, 0);
    instr(0, 0, 8, 1, 0, 0); cyc();
    idle();
    #1 chk("s4_one_left", raw_stall, 1);
    wb_valid = 1; wb_rd = 24;
    cyc();
    idle();
    #1 chk("s4_freed", out_valid, 1);
    cyc();

    // Flush of a stalled instruction
    do_reset();
    instr(4, 1, 0, 0, 0, 0); cyc();
    instr(10, 1, 4, 1, 0, 0); cyc();
    idle();
    #1 chk("s5_stall", raw_stall, 1);
    instr(11, 1, 0, 0, 0, 0);
    flush = 1;
    #1 chk("s5_fl_valid", out_valid, 0);
    chk("s5_fl_stall", raw_stall, 0);
    cyc();
    idle();
    #1 chk("s5_empty", out_valid, 0);
    chk("s5_ready", in_ready, 1);
    cyc();
    instr(0, 0, 4, 1, 0, 0); cyc();
    idle();
    #1 chk("s5_cnt_kept", raw_stall, 1);
    cyc();

    // Release without reservation, and x0 never tracked
    do_reset();
    wb_valid = 1; wb_rd = 9;
    cyc();
    idle();
    chk("s6_err", err, 1);
    cyc(); cyc();
    chk("s6_sticky", err, 1);
    instr(0, 1, 0, 1, 0, 0); cyc();
    instr(16, 1, 16, 1, 0, 0);
    #1 chk("s6_x0_a", out_valid, 1);
    cyc();
    idle();
    #1 chk("s6_x0_b", out_valid, 1);
    chk("s6_x0_nostall", raw_stall, 0);
    cyc();

    // Randomized traffic with legal releases
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        instr($urandom_range(0, 7) + 16 * $urandom_range(0, 1),
              bit'($urandom_range(0, 3) != 0),
              $urandom_range(0, 7) + 16 * $urandom_range(0, 1),
              bit'($urandom_range(0, 1)),
              $urandom_range(0, 7) + 16 * $urandom_range(0, 1),
              bit'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      foreach (mcnt[i]) tmp[i] = mcnt[i];
      r = $urandom_range(1, 7);
      if (tmp[r] > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_rd = 5'(r + 16 * $urandom_range(0, 1));
        tmp[r]--;
      end
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(1, 7);
        if (tmp[r] > 0 && $urandom_range(0, 3) == 0) begin
          kill_valid[k] = 1;
          kill_rd[5*k +: 5] = 5'(r + 16 * $urandom_range(0, 1));
          tmp[r]--;
        end
      end
      cyc();
    end
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
